interrupt_controller8: RTL and testbench
========================================

# interrupt_controller8

Sequential 8-line interrupt controller built around highest-index-wins priority resolution. It captures rising edges on eight request lines into a pending register and applies a per-line mask. The highest-priority unmasked pending line is presented to a single service engine through a req/ack handshake, and the controller then waits for end-of-interrupt before arbitrating again. It sits between raw peripheral request lines and the processor/sequencer that services them.

## Interface
- ACK_TIMEOUT, 15: cycles `int_req` may wait for `int_ack` before withdrawal; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; low blocks new arbitration.
- irq  input  8  request lines; bit 7 is highest priority. Synchronous to clk.
- mask  input  8  1 = line masked from arbitration. Edge capture is unaffected by mask.
- int_ack  input  1  service engine accepts the presented interrupt.
- eoi  input  1  end-of-interrupt for the line currently in service.
- int_req  output  1  interrupt presented.
- int_id  output  3  index of the presented or in-service line.
- pending  output  8  captured, not-yet-acknowledged edges.
- in_service  output  8  one-hot line being serviced; 0 when none.
- timeout_err  output  1  one-cycle pulse on ack timeout.

## Operation
- Edge detect:
  - `irq_d` registers `irq` every cycle.
  - `pending[i]` is set when `irq[i] & ~irq_d[i]`.
  - Capture runs in every state, independent of `en` and `mask`.
- Candidate vector: `pending & ~mask`. The selected line is the highest set index.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - Transition condition: `en` = 1 and candidate ≠ 0.
  - Actions: latch `int_id` = selected index, set `int_req`, clear the timeout counter, go to REQ.
- REQ:
  - `int_req` stays 1 and `int_id` stays frozen, even if mask or pending change.
  - On `int_ack`: clear `pending[int_id]`, set `in_service[int_id]`, drop `int_req`, go to SERVICE.
  - If `en` drops: drop `int_req`, go to IDLE, pending stays unchanged.
  - If the counter reaches ACK_TIMEOUT without ack: drop `int_req`, pulse `timeout_err`, go to IDLE, pending bit is retained.
- SERVICE:
  - `int_id` holds its value.
  - `int_ack` is ignored.
  - On `eoi`: clear `in_service`, go to IDLE.
  - `eoi` in IDLE or REQ is ignored.
- No nesting: a higher-priority line arriving during REQ or SERVICE waits in pending.
- Simultaneous events:
  - When ack clears the same bit that a new edge sets, set wins (`pending` stays 1).
  - `int_ack` together with timeout expiry: ack wins.
  - `int_ack` together with `en` falling: ack wins.
- Timeout counter: 8-bit. Increments each REQ cycle without ack. It never wraps because it is compared before incrementing.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: `int_req`=0, `int_id`=3'b000, `pending`=8'h00, `in_service`=8'h00, `timeout_err`=0.
  - Internal: `irq_d`=8'h00, FSM=IDLE, counter=0.
- Because `irq_d` resets to 0, a line held high through reset release is captured as an edge on the first clock.
- Latency:
  - `irq` rise sampled at edge N → `pending` set after N.
  - `int_req` asserted after edge N+1 (if IDLE, enabled, unmasked).
- Ack: `int_ack` sampled at edge M → after M, `int_req`=0 and `in_service` is set.
- EOI:
  - `eoi` at edge K → after K, `in_service`=0 and state is IDLE.
  - Earliest next `int_req` is after K+1.
- Timeout: `int_req` is high for exactly ACK_TIMEOUT cycles. `timeout_err` is high for the one cycle after the edge at which `int_req` falls.
- Reset mid-operation clears everything immediately. Pending edges are lost.

## Test plan
- Single line: reset, pulse `irq[3]` one cycle, mask=0, en=1.
  - `pending`=8'h08, then `int_req`=1 with `int_id`=3.
  - Ack → `pending`=0, `in_service`=8'h08.
  - eoi → `in_service`=0.
- Priority and no nesting:
  - Raise `irq[2]` and `irq[5]` in the same cycle → `int_id`=5 served first, then `int_id`=2 after eoi.
  - Raise `irq[7]` during SERVICE of 5 → 7 waits in pending and is served before 2.
- Masking:
  - mask=8'h80, pulse `irq[7]` and `irq[1]` → `int_id`=1.
  - `pending[7]` stays 1; clear the mask after eoi → `int_id`=7.
- Timeout with ACK_TIMEOUT=4, no ack:
  - `int_req` high exactly 4 cycles, `timeout_err` one pulse, `pending` bit retained.
  - `int_req` reasserts with the same `int_id` one cycle later.
- Simultaneous ack and re-edge:
  - `irq[4]` rises again in the same cycle `int_ack` is sampled for id 4 → `pending[4]`=1 after ack and `in_service`=8'h10.
  - Ack coincident with the timeout cycle → SERVICE, no `timeout_err`.
- Reset/enable:
  - Assert rst while in REQ → all outputs are at their reset values in the same cycle.
  - Drop `en` in REQ → `int_req` falls next cycle, pending is unchanged.
  - `irq[0]` held high through reset → captured on the first clock after release.

Source files
------------

// File: rtl/interrupt_controller8.sv
// Eight-line edge-capturing interrupt controller: highest unmasked pending index wins,
// presented over a req/ack handshake and held in service until end-of-interrupt.
module interrupt_controller8 #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] irq,
    input  logic [7:0] mask,
    input  logic       int_ack,
    input  logic       eoi,
    output logic       int_req,
    output logic [2:0] int_id,
    output logic [7:0] pending,
    output logic [7:0] in_service,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_irq_d;
    logic [7:0] r_pending;
    logic [7:0] r_in_service;
    logic [2:0] r_int_id;
    logic [7:0] r_cnt;
    logic       r_timeout_err;

    logic [7:0] w_edge;
    logic [7:0] w_cand;
    logic [2:0] w_sel;
    logic       w_expired;
    logic [7:0] w_id_onehot;
    logic       w_latch_id;
    logic       w_take;
    logic       w_release;
    logic       w_timeout;
    logic       w_cnt_inc;
    logic       w_int_req;

    assign w_edge      = irq & ~r_irq_d;
    assign w_cand      = r_pending & ~mask;
    assign w_id_onehot = 8'b1 << r_int_id;
    // Counter is compared before it increments, so it tops out at ACK_TIMEOUT-1 and never wraps.
    assign w_expired   = (r_cnt == 8'(ACK_TIMEOUT - 1));

    // Ascending scan: the last set bit seen is the highest index, which is the winner.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_cand[i]) w_sel = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (en && (w_cand != 8'h00)) w_next_state = REQ;
            REQ: begin
                if (int_ack)        w_next_state = SERVICE;
                else if (!en)       w_next_state = IDLE;
                else if (w_expired) w_next_state = IDLE;
            end
            SERVICE: if (eoi) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ack outranks both enable withdrawal and timeout; a withdrawal by en is not an error.
    always_comb begin
        w_int_req  = (r_state == REQ);
        w_latch_id = (r_state == IDLE) && en && (w_cand != 8'h00);
        w_take     = (r_state == REQ) && int_ack;
        w_timeout  = (r_state == REQ) && !int_ack && en && w_expired;
        w_cnt_inc  = (r_state == REQ) && !int_ack && !w_expired;
        w_release  = (r_state == SERVICE) && eoi;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_d       <= 8'h00;
            r_pending     <= 8'h00;
            r_in_service  <= 8'h00;
            r_int_id      <= 3'd0;
            r_cnt         <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_irq_d       <= irq;
            // A new edge on the bit being acknowledged re-arms it: set beats clear.
            r_pending     <= (r_pending & ~(w_take ? w_id_onehot : 8'h00)) | w_edge;
            r_timeout_err <= w_timeout;
            if (w_take)         r_in_service <= w_id_onehot;
            else if (w_release) r_in_service <= 8'h00;
            if (w_latch_id) r_int_id <= w_sel;
            if (w_latch_id)     r_cnt <= 8'd0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign int_req     = w_int_req;
    assign int_id      = r_int_id;
    assign pending     = r_pending;
    assign in_service  = r_in_service;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_interrupt_controller8.sv
// Vector-table bench for interrupt_controller8 (ACK_TIMEOUT=4): expected outputs are queued
// when each vector is driven and compared one cycle later, plus a hand-written reset sequence.
module tb_interrupt_controller8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] irq;
    logic [7:0] mask;
    logic       int_ack;
    logic       eoi;
    logic       int_req;
    logic [2:0] int_id;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       timeout_err;

    interrupt_controller8 #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .irq(irq), .mask(mask),
        .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id),
        .pending(pending), .in_service(in_service), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Packed output view: {int_req, int_id, pending, in_service, timeout_err}
    typedef struct packed {
        logic       req;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] is;
        logic       te;
    } out_t;

    typedef struct {
        logic       en;
        logic [7:0] irq;
        logic [7:0] mask;
        logic       ack;
        logic       eoi;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic out_t actual();
        return '{int_req, int_id, pending, in_service, timeout_err};
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b id=%0d pend=%h is=%h te=%b, want req=%b id=%0d pend=%h is=%h te=%b",
                     name, act.req, act.id, act.pend, act.is, act.te,
                     exp.req, exp.id, exp.pend, exp.is, exp.te);
        end
    endtask

    task automatic add(input logic e, input logic [7:0] i, input logic [7:0] m,
                       input logic a, input logic o, input logic rq, input logic [2:0] id,
                       input logic [7:0] pd, input logic [7:0] is, input logic te);
        vec_t v;
        v.en = e; v.irq = i; v.mask = m; v.ack = a; v.eoi = o;
        v.exp = '{rq, id, pd, is, te};
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string name);
        out_t exp;
        @(negedge clk);
        en = v.en; irq = v.irq; mask = v.mask; int_ack = v.ack; eoi = v.eoi;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = sb.pop_front();
            check(name, actual(), exp);
        end
    endtask

    initial begin
        vec_t v;
        // Single line
        add(1,8'h08,8'h00,0,0, 0,0,8'h08,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,3,8'h08,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,3,8'h00,8'h08,0);
        add(1,8'h00,8'h00,0,0, 0,3,8'h00,8'h08,0);
        add(1,8'h00,8'h00,0,1, 0,3,8'h00,8'h00,0);
        // Priority 5 over 2; 7 arrives during service of 5 and waits
        add(1,8'h24,8'h00,0,0, 0,3,8'h24,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,5,8'h24,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,5,8'h04,8'h20,0);
        add(1,8'h80,8'h00,0,0, 0,5,8'h84,8'h20,0);
        add(1,8'h00,8'h00,0,1, 0,5,8'h84,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,7,8'h84,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,7,8'h04,8'h80,0);
        add(1,8'h00,8'h00,0,1, 0,7,8'h04,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,2,8'h04,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,2,8'h00,8'h04,0);
        add(1,8'h00,8'h00,0,1, 0,2,8'h00,8'h00,0);
        // Masking
        add(1,8'h82,8'h80,0,0, 0,2,8'h82,8'h00,0);
        add(1,8'h00,8'h80,0,0, 1,1,8'h82,8'h00,0);
        add(1,8'h00,8'h80,1,0, 0,1,8'h80,8'h02,0);
        add(1,8'h00,8'h80,0,1, 0,1,8'h80,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,7,8'h80,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,7,8'h00,8'h80,0);
        add(1,8'h00,8'h00,0,1, 0,7,8'h00,8'h00,0);
        // Ack timeout: req high 4 cycles, one error pulse, then re-request
        add(1,8'h01,8'h00,0,0, 0,7,8'h01,8'h00,0);
        for (int k = 0; k < 4; k++) add(1,8'h00,8'h00,0,0, 1,0,8'h01,8'h00,0);
        add(1,8'h00,8'h00,0,0, 0,0,8'h01,8'h00,1);
        add(1,8'h00,8'h00,0,0, 1,0,8'h01,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,0,8'h00,8'h01,0);
        add(1,8'h00,8'h00,0,1, 0,0,8'h00,8'h00,0);
        // Ack with coincident re-edge, then ack on the timeout cycle
        add(1,8'h10,8'h00,0,0, 0,0,8'h10,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,4,8'h10,8'h00,0);
        add(1,8'h10,8'h00,1,0, 0,4,8'h10,8'h10,0);
        add(1,8'h00,8'h00,0,1, 0,4,8'h10,8'h00,0);
        for (int k = 0; k < 4; k++) add(1,8'h00,8'h00,0,0, 1,4,8'h10,8'h00,0);
        add(1,8'h00,8'h00,1,0, 0,4,8'h00,8'h10,0);
        add(1,8'h00,8'h00,0,1, 0,4,8'h00,8'h00,0);
        // Enable withdrawal, then ack beating en falling
        add(1,8'h40,8'h00,0,0, 0,4,8'h40,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,6,8'h40,8'h00,0);
        add(0,8'h00,8'h00,0,0, 0,6,8'h40,8'h00,0);
        add(0,8'h00,8'h00,0,0, 0,6,8'h40,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,6,8'h40,8'h00,0);
        add(0,8'h00,8'h00,1,0, 0,6,8'h00,8'h40,0);
        add(1,8'h00,8'h00,0,1, 0,6,8'h00,8'h00,0);
        // Walk into REQ for the async reset sequence
        add(1,8'h08,8'h00,0,0, 0,6,8'h08,8'h00,0);
        add(1,8'h00,8'h00,0,0, 1,3,8'h08,8'h00,0);

        rst = 1'b1; en = 1'b0; irq = 8'h00; mask = 8'h00; int_ack = 1'b0; eoi = 1'b0;
        #2;
        check("reset_values", actual(), out_t'(21'h0));
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            apply(v, $sformatf("vec%0d", n));
        end

        // Reset asserted mid-REQ must clear outputs without waiting for a clock
        @(negedge clk);
        rst = 1'b1;
        irq = 8'h01;
        #1;
        check("async_reset_in_req", actual(), out_t'(21'h0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("irq0_held_through_reset", actual(), '{1'b0, 3'd0, 8'h01, 8'h00, 1'b0});
        @(posedge clk);
        #1;
        check("irq0_req_after_reset", actual(), '{1'b1, 3'd0, 8'h01, 8'h00, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
